// File: rtl/in_packet_pkg.sv
// Shared definitions for the in_packet FIFO-pair writer: state encoding,
// header field offsets and word geometry helpers.
package in_packet_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE0 = 2'd1,
        WRITE1 = 2'd2,
        DROP   = 2'd3
    } state_e;

    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    // Header word layout: length in the top 16 bits, type in the next 8.
    function automatic int len_msb(input int dw);
        return dw - 1;
    endfunction

    function automatic int len_lsb(input int dw);
        return dw - 16;
    endfunction

    function automatic int type_msb(input int dw);
        return dw - 17;
    endfunction

    function automatic int type_lsb(input int dw);
        return dw - 24;
    endfunction

    function automatic int bytes_per_word(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/in_packet.sv
// Writer side of the packet FIFO pair: steers each InBus packet whole into one
// of two FIFOs. Define IN_PACKET_LEN_CHECK_EN to add the header length check.
module in_packet
    import in_packet_pkg::*;
#(
    parameter int DAT_WIDTH = 64
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         InBus_Val,
    input  logic                         InBus_Sop,
    input  logic                         InBus_Eop,
    input  logic [$clog2(DAT_WIDTH/8):0] InBus_Mod,
    input  logic [DAT_WIDTH-1:0]         InBus_Dat,
    input  logic                         fifo0_full,
    output logic                         fifo0_wr,
    output logic                         fifo0_busy,
    output logic [DAT_WIDTH-1:0]         fifo0_data_in,
    input  logic                         fifo1_full,
    output logic                         fifo1_wr,
    output logic                         fifo1_busy,
    output logic [DAT_WIDTH-1:0]         fifo1_data_in,
    output logic                         InBus_Error,
    output logic [15:0]                  drop_cnt
);

    state_e               state, state_nxt;
    logic                 ptr, ptr_nxt;
    logic [1:0]           wr_q, wr_nxt;
    logic [1:0]           busy_q, busy_nxt;
    logic                 err_q, err_nxt;
    logic [15:0]          drop_q, drop_nxt;
    logic [DAT_WIDTH-1:0] data_q, data_nxt;

    logic [1:0] full;
    logic       cur;
    logic       start;
    logic       sel_ptr;
    logic       tgt;
    logic       drop_evt;
    logic       accept_sop;

`ifdef IN_PACKET_LEN_CHECK_EN
    localparam int LEN_MSB = len_msb(DAT_WIDTH);
    localparam int LEN_LSB = len_lsb(DAT_WIDTH);

    logic [15:0] byte_cnt, byte_cnt_nxt;
    logic [15:0] hdr_len, hdr_len_nxt;
    logic [15:0] byte_sum;
    logic [15:0] exp_len;
`else
    logic unused_mod;
    assign unused_mod = ^InBus_Mod;
`endif

    assign full = {fifo1_full, fifo0_full};
    assign cur  = (state == WRITE1);

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path can infer a latch.
        state_nxt  = state;
        ptr_nxt    = ptr;
        wr_nxt     = '0;
        err_nxt    = 1'b0;
        data_nxt   = data_q;
        start      = 1'b0;
        sel_ptr    = ptr;
        tgt        = 1'b0;
        drop_evt   = 1'b0;
        accept_sop = 1'b0;

        case (state)
            IDLE: begin
                if (InBus_Val) begin
                    if (InBus_Sop) start   = 1'b1;
                    else           err_nxt = 1'b1;
                end
            end
            WRITE0, WRITE1: begin
                if (InBus_Val) begin
                    if (InBus_Sop) begin
                        // The interrupted packet stays closed on its FIFO; try the other FIFO first.
                        err_nxt   = 1'b1;
                        start     = 1'b1;
                        sel_ptr   = ~cur;
                        ptr_nxt   = ~cur;
                        state_nxt = IDLE;
                    end else if (full[cur]) begin
                        err_nxt   = 1'b1;
                        drop_evt  = 1'b1;
                        state_nxt = InBus_Eop ? IDLE : DROP;
                    end else begin
                        wr_nxt[cur] = 1'b1;
                        data_nxt    = InBus_Dat;
                        if (InBus_Eop) begin
                            state_nxt = IDLE;
                            ptr_nxt   = ~cur;
                        end
                    end
                end
            end
            DROP: begin
                if (InBus_Val) begin
                    if (InBus_Sop) begin
                        err_nxt   = 1'b1;
                        start     = 1'b1;
                        state_nxt = IDLE;
                    end else if (InBus_Eop) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start) begin
            if (!full[sel_ptr]) begin
                tgt        = sel_ptr;
                accept_sop = 1'b1;
            end else if (!full[~sel_ptr]) begin
                tgt        = ~sel_ptr;
                accept_sop = 1'b1;
            end else begin
                drop_evt  = 1'b1;
                state_nxt = InBus_Eop ? IDLE : DROP;
            end
            if (accept_sop) begin
                wr_nxt[tgt] = 1'b1;
                data_nxt    = InBus_Dat;
                if (InBus_Eop) begin
                    state_nxt = IDLE;
                    ptr_nxt   = ~tgt;
                end else begin
                    state_nxt = tgt ? WRITE1 : WRITE0;
                end
            end
        end

        drop_nxt = drop_q;
        if (drop_evt && drop_q != DROP_CNT_MAX) drop_nxt = drop_q + 16'd1;

        busy_nxt[0] = wr_nxt[0] | (state_nxt == WRITE0);
        busy_nxt[1] = wr_nxt[1] | (state_nxt == WRITE1);

`ifdef IN_PACKET_LEN_CHECK_EN
        byte_sum     = (accept_sop ? 16'd0 : byte_cnt) + 16'(InBus_Mod);
        exp_len      = accept_sop ? InBus_Dat[LEN_MSB:LEN_LSB] : hdr_len;
        byte_cnt_nxt = byte_cnt;
        hdr_len_nxt  = hdr_len;
        if (|wr_nxt) begin
            byte_cnt_nxt = byte_sum;
            hdr_len_nxt  = exp_len;
            if (InBus_Eop && byte_sum != exp_len) err_nxt = 1'b1;
        end
`endif
    end

    // NOTE: Rst is synchronous, so it is only sampled inside the clocked process.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            wr_q   <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
            drop_q <= '0;
            data_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            wr_q   <= wr_nxt;
            busy_q <= busy_nxt;
            err_q  <= err_nxt;
            drop_q <= drop_nxt;
            data_q <= data_nxt;
        end
    end

`ifdef IN_PACKET_LEN_CHECK_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            byte_cnt <= '0;
            hdr_len  <= '0;
        end else begin
            byte_cnt <= byte_cnt_nxt;
            hdr_len  <= hdr_len_nxt;
        end
    end
`endif

    assign fifo0_wr      = wr_q[0];
    assign fifo1_wr      = wr_q[1];
    assign fifo0_busy    = busy_q[0];
    assign fifo1_busy    = busy_q[1];
    assign fifo0_data_in = data_q;
    assign fifo1_data_in = data_q;
    assign InBus_Error   = err_q;
    assign drop_cnt      = drop_q;

endmodule
